// File: rtl/alu_result_display_pkg.sv
// Shared types and constants for the ALU result display: FSM states,
// special segment patterns and the hex digit font.
package alu_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_GAP_S,
        ST_HI,
        ST_GAP_HI,
        ST_LO,
        ST_GAP_LO
    } state_e;

    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] DP_BIT    = 8'h80;

    // Segment order {g,f,e,d,c,b,a}; entry 15 first.
    localparam logic [15:0][6:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] magnitude(input logic [7:0] v, input logic neg);
        magnitude = neg ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Bus between the ALU stage and the display block: capture request in,
// segment drive and busy status out.
interface alu_result_display_if;
    logic       ena;
    logic [7:0] result_in;
    logic       result_valid;
    logic       signed_in;
    logic [7:0] seg_out;
    logic       busy;

    modport master (
        output ena, result_in, result_valid, signed_in,
        input  seg_out, busy
    );

    modport slave (
        input  ena, result_in, result_valid, signed_in,
        output seg_out, busy
    );
endinterface

// File: rtl/alu_result_display_hex_to_7seg.sv
// Combinational hex nibble to 7-segment decoder (a = bit 0).
module hex_to_7seg
    import alu_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = FONT[nibble_i];
endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result and cycles it on one 7-segment digit as
// [minus] high-nibble low-nibble.dp, each digit followed by a blank gap.
module alu_result_display #(
    parameter int DWELL_CYCLES = 1000000,
    parameter int GAP_CYCLES   = 250000
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_result_display_if.slave bus
);
    import alu_display_pkg::*;

    localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [7:0]       seg_q, seg_d;
    logic             busy_q, busy_d;

    logic             capture, cap_neg, lit, last;
    logic [3:0]       nibble;
    logic [6:0]       font_seg;

    assign capture = bus.ena & bus.result_valid;
    assign cap_neg = bus.signed_in & bus.result_in[7];

    // ena low freezes every register, so a strobe during the freeze is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
            busy_q  <= 1'b0;
        end else if (bus.ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        lit     = (state_q == ST_SIGN) || (state_q == ST_HI) || (state_q == ST_LO);
        last    = (cnt_q == (lit ? DWELL_LAST : GAP_LAST));
        if (capture) begin
            neg_d   = cap_neg;
            mag_d   = magnitude(bus.result_in, cap_neg);
            state_d = cap_neg ? ST_SIGN : ST_HI;
            cnt_d   = '0;
        end else if (state_q != ST_IDLE) begin
            if (last) begin
                cnt_d = '0;
                unique case (state_q)
                    ST_SIGN:   state_d = ST_GAP_S;
                    ST_GAP_S:  state_d = ST_HI;
                    ST_HI:     state_d = ST_GAP_HI;
                    ST_GAP_HI: state_d = ST_LO;
                    ST_LO:     state_d = ST_GAP_LO;
                    ST_GAP_LO: state_d = neg_q ? ST_SIGN : ST_HI;
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign nibble = (state_q == ST_LO) ? mag_q[3:0] : mag_q[7:4];

    hex_to_7seg u_font (
        .nibble_i (nibble),
        .seg_o    (font_seg)
    );

    // Segments follow the registered state, giving the one-cycle capture latency.
    always_comb begin
        seg_d = SEG_BLANK;
        unique case (state_q)
            ST_SIGN: seg_d = SEG_MINUS;
            ST_HI:   seg_d = {1'b0, font_seg};
            ST_LO:   seg_d = {1'b0, font_seg} | DP_BIT;
            default: seg_d = SEG_BLANK;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.seg_out = seg_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display with DWELL_CYCLES=4, GAP_CYCLES=2.
module tb_alu_result_display;
    localparam int DWELL = 4;
    localparam int GAP   = 2;

    logic clk;
    logic rst_n;
    alu_result_display_if bus ();

    alu_result_display #(.DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one flattened per-cycle pattern of the whole display loop.
    logic [7:0] tb_font [16];
    logic [7:0] m_pat [32];
    int         m_len;
    int         m_p;
    logic [7:0] m_seg;
    logic       m_busy;

    typedef struct {
        logic [7:0] res;
        logic       sgn;
        logic       neg;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_build(input logic [7:0] r, input logic s);
        int mag;
        logic [7:0] digs [3];
        int nd;
        mag = (s && r >= 8'd128) ? (256 - int'(r)) % 256 : int'(r);
        nd  = 0;
        if (s && r >= 8'd128) begin
            digs[nd] = 8'h40;
            nd++;
        end
        digs[nd] = tb_font[mag / 16];
        nd++;
        digs[nd] = tb_font[mag % 16] + 8'h80;
        nd++;
        m_len = 0;
        for (int d = 0; d < nd; d++) begin
            for (int c = 0; c < DWELL; c++) begin
                m_pat[m_len] = digs[d];
                m_len++;
            end
            for (int c = 0; c < GAP; c++) begin
                m_pat[m_len] = 8'h00;
                m_len++;
            end
        end
    endtask

    task automatic model_step(input logic e, input logic v, input logic [7:0] r, input logic s);
        if (e) begin
            m_seg = (m_len == 0) ? 8'h00 : m_pat[m_p];
            if (v) begin
                model_build(r, s);
                m_p    = 0;
                m_busy = 1'b1;
            end else if (m_len != 0) begin
                m_p = (m_p + 1) % m_len;
            end
        end
    endtask

    task automatic model_reset();
        m_len  = 0;
        m_p    = 0;
        m_seg  = 8'h00;
        m_busy = 1'b0;
    endtask

    task automatic tick(input logic e, input logic v, input logic [7:0] r, input logic s);
        bus.ena          = e;
        bus.result_valid = v;
        bus.result_in    = r;
        bus.signed_in    = s;
        @(posedge clk);
        if (rst_n) model_step(e, v, r, s);
        @(negedge clk);
        check("seg_model", bus.seg_out, m_seg);
        check("busy_model", {7'd0, bus.busy}, {7'd0, m_busy});
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] digs [3];
        int nd, pos, exp_seg;

        tb_font = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        vecs[0] = '{res: 8'h3A, sgn: 1'b0, neg: 1'b0, hi: 8'h4F, lo: 8'hF7};
        vecs[1] = '{res: 8'hF3, sgn: 1'b1, neg: 1'b1, hi: 8'h3F, lo: 8'hDE};
        vecs[2] = '{res: 8'h80, sgn: 1'b1, neg: 1'b1, hi: 8'h7F, lo: 8'hBF};
        vecs[3] = '{res: 8'h05, sgn: 1'b0, neg: 1'b0, hi: 8'h3F, lo: 8'hED};
        vecs[4] = '{res: 8'hFF, sgn: 1'b1, neg: 1'b1, hi: 8'h3F, lo: 8'h86};
        vecs[5] = '{res: 8'hFF, sgn: 1'b0, neg: 1'b0, hi: 8'h71, lo: 8'hF1};
        vecs[6] = '{res: 8'h7F, sgn: 1'b1, neg: 1'b0, hi: 8'h07, lo: 8'hF1};
        vecs[7] = '{res: 8'h00, sgn: 1'b1, neg: 1'b0, hi: 8'h3F, lo: 8'hBF};

        model_reset();
        bus.ena = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_in = 8'h00;
        bus.signed_in = 1'b0;
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) idle();
        check("reset_seg", bus.seg_out, 8'h00);
        check("reset_busy", {7'd0, bus.busy}, 8'h00);

        // Table-driven: capture each vector and watch two full display loops.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, vecs[i].res, vecs[i].sgn);
            check("cap_busy", {7'd0, bus.busy}, 8'h01);
            nd = 0;
            if (vecs[i].neg) begin
                digs[nd] = 8'h40;
                nd++;
            end
            digs[nd] = vecs[i].hi;
            nd++;
            digs[nd] = vecs[i].lo;
            nd++;
            for (int k = 0; k < 2 * 6 * nd + 1; k++) begin
                idle();
                pos = k % (6 * nd);
                exp_seg = (pos % 6 < 4) ? int'(digs[pos / 6]) : 0;
                check("table_seg", bus.seg_out, 8'(exp_seg));
            end
        end

        // Mid-digit restart on the second cycle of LO.
        tick(1'b1, 1'b1, 8'h3A, 1'b0);
        for (int k = 0; k < 7; k++) idle();
        check("pre_restart_lo", bus.seg_out, 8'hF7);
        tick(1'b1, 1'b1, 8'h05, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle();
            check("restart_dwell", bus.seg_out, 8'h3F);
        end
        idle();
        check("restart_gap", bus.seg_out, 8'h00);

        // Freeze in the middle of HI with an ignored strobe.
        tick(1'b1, 1'b1, 8'h3A, 1'b0);
        idle();
        idle();
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, (k == 2), 8'hFF, 1'b1);
            check("freeze_seg", bus.seg_out, 8'h4F);
        end
        idle();
        check("thaw_hi3", bus.seg_out, 8'h4F);
        idle();
        check("thaw_hi4", bus.seg_out, 8'h4F);
        idle();
        check("thaw_gap", bus.seg_out, 8'h00);
        for (int k = 0; k < 3; k++) idle();
        check("thaw_lo", bus.seg_out, 8'hF7);

        // Async reset between edges while LO is shown.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_seg", bus.seg_out, 8'h00);
        check("async_busy", {7'd0, bus.busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) idle();
        check("post_reset_idle", bus.seg_out, 8'h00);
        check("post_reset_busy", {7'd0, bus.busy}, 8'h00);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 1500; k++) begin
            tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
